// File: rtl/plic_pending_arbiter_if.sv
// Gateway handshake, hart configuration and claim/complete bus between the
// register-bus front end / gateways and the pending arbiter.
interface plic_pending_arbiter_if #(
  parameter int unsigned N_SOURCES = 8,
  parameter int unsigned PRIO_W    = 3,
  parameter int unsigned ID_W      = 4
);
  logic [N_SOURCES-1:0]        gw_valid;
  logic [N_SOURCES-1:0]        gw_ready;
  logic [N_SOURCES-1:0]        gw_complete;
  logic [N_SOURCES*PRIO_W-1:0] prio;
  logic [N_SOURCES-1:0]        enable;
  logic [PRIO_W-1:0]           threshold;
  logic                        claim_req;
  logic                        claim_valid;
  logic [ID_W-1:0]             claim_id;
  logic                        complete_req;
  logic [ID_W-1:0]             complete_id;
  logic                        irq;

  modport master (
    output gw_valid, prio, enable, threshold, claim_req, complete_req, complete_id,
    input  gw_ready, gw_complete, claim_valid, claim_id, irq
  );

  modport slave (
    input  gw_valid, prio, enable, threshold, claim_req, complete_req, complete_id,
    output gw_ready, gw_complete, claim_valid, claim_id, irq
  );
endinterface

// File: rtl/plic_pending_arbiter.sv
// Per-source pending bits behind the level gateways, max-priority arbitration
// (lowest ID wins ties), hart irq generation and claim/complete servicing.
module plic_pending_arbiter #(
  parameter int unsigned N_SOURCES = 8,
  parameter int unsigned PRIO_W    = 3,
  parameter int unsigned ID_W      = 4
) (
  input logic                  clk,
  input logic                  reset,
  plic_pending_arbiter_if.slave bus
);

  logic [N_SOURCES-1:0] pending;
  logic [N_SOURCES-1:0] set_mask;
  logic [N_SOURCES-1:0] claim_clr;
  logic [N_SOURCES-1:0] cpl_onehot;
  logic [ID_W-1:0]      best_id;
  logic [PRIO_W-1:0]    best_prio;
  logic                 win;
  logic                 cpl_hit;

  assign bus.gw_ready = ~pending;
  assign set_mask     = bus.gw_valid & ~pending;

  // Strictly-greater update keeps the lowest ID on ties and excludes priority 0.
  always_comb begin
    best_id   = '0;
    best_prio = '0;
    for (int i = 0; i < int'(N_SOURCES); i++) begin
      if (pending[i] && bus.enable[i] &&
          (bus.prio[i*PRIO_W +: PRIO_W] > best_prio)) begin
        best_prio = bus.prio[i*PRIO_W +: PRIO_W];
        best_id   = ID_W'(i + 1);
      end
    end
  end

  assign win = (best_prio > bus.threshold);

  // A winning claim implies best_prio > 0, so best_id is a real source here.
  always_comb begin
    claim_clr = '0;
    if (bus.claim_req && win) begin
      claim_clr = N_SOURCES'(1) << (best_id - ID_W'(1));
    end
  end

  always_comb begin
    cpl_hit    = bus.complete_req && (bus.complete_id != '0) &&
                 (bus.complete_id <= ID_W'(N_SOURCES));
    cpl_onehot = '0;
    if (cpl_hit) begin
      cpl_onehot = N_SOURCES'(1) << (bus.complete_id - ID_W'(1));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending         <= '0;
      bus.gw_complete <= '0;
      bus.claim_valid <= 1'b0;
      bus.claim_id    <= '0;
      bus.irq         <= 1'b0;
    end else begin
      pending         <= (pending | set_mask) & ~claim_clr;
      bus.gw_complete <= cpl_onehot;
      bus.claim_valid <= bus.claim_req;
      bus.irq         <= win;
      if (bus.claim_req) begin
        bus.claim_id <= win ? best_id : '0;
      end
    end
  end

endmodule

// File: tb/tb_plic_pending_arbiter.sv
// Bench for plic_pending_arbiter: directed tables, hand sequences for the
// multi-cycle cases, and random traffic against a cycle-level reference model.
module tb_plic_pending_arbiter;
  localparam int unsigned N  = 8;
  localparam int unsigned PW = 3;
  localparam int unsigned IW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  plic_pending_arbiter_if #(.N_SOURCES(N), .PRIO_W(PW), .ID_W(IW)) bus ();

  plic_pending_arbiter #(.N_SOURCES(N), .PRIO_W(PW), .ID_W(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit           m_pend [1:N];
  bit           m_irq;
  bit           m_cv;
  int           m_cid;
  logic [N-1:0] m_gwc;

  typedef struct {
    logic [N-1:0]    valid;
    logic [N*PW-1:0] prio;
    logic [N-1:0]    en;
    logic [PW-1:0]   thr;
    logic [IW-1:0]   exp_id;
    logic            exp_irq;
  } arb_vec_t;

  typedef struct {
    logic [IW-1:0] id;
    logic [N-1:0]  exp;
  } cpl_vec_t;

  arb_vec_t av [8];
  cpl_vec_t cv [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N*PW-1:0] pv(input int p [8]);
    logic [N*PW-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*PW +: PW] = PW'(p[i]);
    return r;
  endfunction

  function automatic int prio_of(input int s);
    return int'(bus.prio[(s-1)*PW +: PW]);
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] v;
    for (int s = 1; s <= int'(N); s++) v[s-1] = ~m_pend[s];
    return v;
  endfunction

  // Search from the highest priority level down; first enabled pending source
  // found by ascending ID at that level wins.
  task automatic model_best(output int id, output int p);
    id = 0;
    p  = 0;
    for (int pr = (1 << PW) - 1; pr >= 1; pr--) begin
      for (int s = 1; s <= int'(N); s++) begin
        if (id == 0 && m_pend[s] && bus.enable[s-1] && prio_of(s) == pr) begin
          id = s;
          p  = pr;
        end
      end
    end
  endtask

  task automatic model_edge();
    int  bid, bp, cid;
    bit  win;
    model_best(bid, bp);
    win   = bp > int'(bus.threshold);
    cid   = int'(bus.complete_id);
    m_gwc = '0;
    if (bus.complete_req && cid >= 1 && cid <= int'(N)) m_gwc[cid-1] = 1'b1;
    for (int s = 1; s <= int'(N); s++) if (bus.gw_valid[s-1]) m_pend[s] = 1'b1;
    if (bus.claim_req && win) m_pend[bid] = 1'b0;
    m_irq = win;
    m_cv  = bus.claim_req;
    if (bus.claim_req) m_cid = win ? bid : 0;
  endtask

  task automatic model_reset();
    for (int s = 1; s <= int'(N); s++) m_pend[s] = 1'b0;
    m_irq = 1'b0;
    m_cv  = 1'b0;
    m_cid = 0;
    m_gwc = '0;
  endtask

  task automatic check_all();
    check("model_claim_valid", 32'(bus.claim_valid), 32'(m_cv));
    check("model_claim_id",    32'(bus.claim_id),    32'(m_cid));
    check("model_irq",         32'(bus.irq),         32'(m_irq));
    check("model_gw_ready",    32'(bus.gw_ready),    32'(exp_ready()));
    check("model_gw_complete", 32'(bus.gw_complete), 32'(m_gwc));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    bus.gw_valid     = '0;
    bus.claim_req    = 1'b0;
    bus.complete_req = 1'b0;
    bus.complete_id  = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    model_reset();
    #1;
    check("reset_claim_valid", 32'(bus.claim_valid), 32'd0);
    check("reset_irq",         32'(bus.irq),         32'd0);
    check("reset_gw_ready",    32'(bus.gw_ready),    32'hFF);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset         = 1'b0;
    bus.prio      = '0;
    bus.enable    = '1;
    bus.threshold = '0;
    idle();

    av[0] = '{8'h04, pv('{0,0,5,0,0,0,0,0}), 8'hFF, 3'd2, 4'd3, 1'b1};
    av[1] = '{8'h32, pv('{0,4,0,0,7,7,0,0}), 8'hFF, 3'd0, 4'd5, 1'b1};
    av[2] = '{8'h01, pv('{3,0,0,0,0,0,0,0}), 8'hFF, 3'd3, 4'd0, 1'b0};
    av[3] = '{8'h08, pv('{0,0,0,0,0,0,0,0}), 8'hFF, 3'd0, 4'd0, 1'b0};
    av[4] = '{8'hFF, pv('{2,2,2,2,2,2,2,2}), 8'h00, 3'd0, 4'd0, 1'b0};
    av[5] = '{8'hFF, pv('{2,2,2,2,2,2,2,2}), 8'hF0, 3'd1, 4'd5, 1'b1};
    av[6] = '{8'hFF, pv('{6,6,6,6,6,6,6,7}), 8'hFF, 3'd6, 4'd8, 1'b1};
    av[7] = '{8'h81, pv('{7,0,0,0,0,0,0,7}), 8'hFF, 3'd7, 4'd0, 1'b0};

    cv[0] = '{4'd0,  8'h00};
    cv[1] = '{4'd1,  8'h01};
    cv[2] = '{4'd3,  8'h04};
    cv[3] = '{4'd8,  8'h80};
    cv[4] = '{4'd9,  8'h00};
    cv[5] = '{4'd15, 8'h00};

    do_reset();

    // Arbitration table: load pending, wait for irq, claim once
    for (int k = 0; k < 8; k++) begin
      do_reset();
      bus.prio      = av[k].prio;
      bus.enable    = av[k].en;
      bus.threshold = av[k].thr;
      bus.gw_valid  = av[k].valid;
      step();
      idle();
      step();
      check($sformatf("arb_irq[%0d]", k), 32'(bus.irq), 32'(av[k].exp_irq));
      bus.claim_req = 1'b1;
      step();
      idle();
      check($sformatf("arb_id[%0d]", k), 32'(bus.claim_id), 32'(av[k].exp_id));
    end

    // Complete decode table
    do_reset();
    for (int k = 0; k < 6; k++) begin
      bus.complete_req = 1'b1;
      bus.complete_id  = cv[k].id;
      step();
      idle();
      check($sformatf("cpl[%0d]", k), 32'(bus.gw_complete), 32'(cv[k].exp));
      step();
      check($sformatf("cpl_off[%0d]", k), 32'(bus.gw_complete), 32'd0);
    end

    // Single source latency
    do_reset();
    bus.prio = pv('{0,0,5,0,0,0,0,0}); bus.enable = 8'hFF; bus.threshold = 3'd2;
    bus.gw_valid = 8'h04;
    step(); idle();
    check("single_ready", 32'(bus.gw_ready), 32'hFB);
    check("single_irq_lat", 32'(bus.irq), 32'd0);
    step();
    check("single_irq", 32'(bus.irq), 32'd1);
    bus.claim_req = 1'b1;
    step(); idle();
    check("single_cv", 32'(bus.claim_valid), 32'd1);
    check("single_cid", 32'(bus.claim_id), 32'd3);
    check("single_ready2", 32'(bus.gw_ready), 32'hFF);
    step();
    check("single_irq_off", 32'(bus.irq), 32'd0);
    check("single_cv_off", 32'(bus.claim_valid), 32'd0);

    // Back-to-back claims with tie-break
    do_reset();
    bus.prio = pv('{0,4,0,0,7,7,0,0}); bus.enable = 8'hFF; bus.threshold = 3'd0;
    bus.gw_valid = 8'h32;
    step(); idle();
    bus.claim_req = 1'b1;
    step(); check("b2b_1", 32'(bus.claim_id), 32'd5);
    step(); check("b2b_2", 32'(bus.claim_id), 32'd6);
    step(); check("b2b_3", 32'(bus.claim_id), 32'd2);
    step(); check("b2b_4", 32'(bus.claim_id), 32'd0);
    check("b2b_cv", 32'(bus.claim_valid), 32'd1);
    idle();
    step(); check("b2b_cv_off", 32'(bus.claim_valid), 32'd0);

    // Threshold blocks claim and pending is kept
    do_reset();
    bus.prio = pv('{3,0,0,0,0,0,0,0}); bus.threshold = 3'd3;
    bus.gw_valid = 8'h01;
    step(); idle(); step();
    bus.claim_req = 1'b1;
    step(); idle();
    check("thr_cid", 32'(bus.claim_id), 32'd0);
    check("thr_kept", 32'(bus.gw_ready), 32'hFE);

    // Claim, gateway set and complete in one cycle
    do_reset();
    bus.prio = pv('{0,3,0,0,0,0,0,0}); bus.threshold = 3'd0;
    bus.gw_valid = 8'h02;
    step(); idle();
    bus.claim_req = 1'b1; bus.gw_valid = 8'h40;
    bus.complete_req = 1'b1; bus.complete_id = 4'd1;
    step(); idle();
    check("simul_cid", 32'(bus.claim_id), 32'd2);
    check("simul_cpl", 32'(bus.gw_complete), 32'h01);
    check("simul_ready", 32'(bus.gw_ready), 32'hBF);

    // Enable masking keeps pending
    do_reset();
    bus.prio = pv('{0,0,0,6,0,0,0,0}); bus.enable = 8'hFF; bus.threshold = 3'd0;
    bus.gw_valid = 8'h08;
    step(); idle(); step();
    check("en_irq_on", 32'(bus.irq), 32'd1);
    bus.enable = 8'hF7;
    step();
    check("en_irq_masked", 32'(bus.irq), 32'd0);
    check("en_pending_kept", 32'(bus.gw_ready), 32'hF7);
    bus.enable = 8'hFF;
    step();
    check("en_irq_back", 32'(bus.irq), 32'd1);

    // Reset in the middle of a claim response
    bus.claim_req = 1'b1;
    step(); idle();
    check("midrst_cv", 32'(bus.claim_valid), 32'd1);
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    check("midrst_cv_drop", 32'(bus.claim_valid), 32'd0);
    check("midrst_ready", 32'(bus.gw_ready), 32'hFF);
    check("midrst_irq", 32'(bus.irq), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 16 == 0) begin
        bus.prio      = (N*PW)'({$urandom, $urandom});
        bus.threshold = PW'($urandom_range(0, 4));
      end
      bus.enable       = N'($urandom | $urandom);
      bus.gw_valid     = N'($urandom & $urandom);
      bus.claim_req    = ($urandom_range(0, 9) < 3);
      bus.complete_req = ($urandom_range(0, 9) < 3);
      bus.complete_id  = IW'($urandom_range(0, 15));
      step();
    end
    idle();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
